// File: rtl/rggen_apb_bridge_master.sv
// Bridges a valid/ready register request onto an APB master port.
// One transaction in flight; optional ACCESS-phase timeout.
module rggen_apb_bridge_master #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDRESS_WIDTH-1:0]  req_address,
    input  logic                      req_write,
    input  logic [DATA_WIDTH-1:0]     req_write_data,
    input  logic [DATA_WIDTH/8-1:0]   req_strobe,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_read_data,
    output logic [1:0]                rsp_status,
    output logic                      psel,
    output logic                      penable,
    output logic [ADDRESS_WIDTH-1:0]  paddr,
    output logic [2:0]                pprot,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT =
        (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESPONSE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          timeout;

    // count holds the number of ACCESS cycles already spent waiting
    assign timeout   = (TIMEOUT_CYCLES > 0) && (count == LIMIT);
    assign req_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            psel          <= 1'b0;
            penable       <= 1'b0;
            paddr         <= '0;
            pprot         <= '0;
            pwrite        <= 1'b0;
            pwdata        <= '0;
            pstrb         <= '0;
            rsp_valid     <= 1'b0;
            rsp_read_data <= '0;
            rsp_status    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        paddr   <= req_address;
                        pprot   <= req_prot;
                        pwrite  <= req_write;
                        pwdata  <= req_write_data;
                        pstrb   <= req_write ? req_strobe : '0;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        count   <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel          <= 1'b0;
                        penable       <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_read_data <= pwrite ? '0 : prdata;
                        rsp_status    <= pslverr ? 2'd1 : 2'd0;
                        state         <= RESPONSE;
                    end else if (timeout) begin
                        psel          <= 1'b0;
                        penable       <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_read_data <= '0;
                        rsp_status    <= 2'd2;
                        state         <= RESPONSE;
                    end else if (count != '1) begin
                        count <= count + 1'b1;
                    end
                end
                RESPONSE: begin
                    if (rsp_ready) begin
                        rsp_valid     <= 1'b0;
                        rsp_read_data <= '0;
                        rsp_status    <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_apb_bridge_master.sv
// Directed bench for rggen_apb_bridge_master: one instance with a
// 4-cycle timeout and one with the timeout disabled, sharing stimulus.
module tb_rggen_apb_bridge_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_address;
    logic        req_write;
    logic [31:0] req_write_data;
    logic [3:0]  req_strobe;
    logic [2:0]  req_prot;
    logic        rsp_ready;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    logic        req_ready, rsp_valid, psel, penable, pwrite;
    logic [31:0] rsp_read_data, pwdata;
    logic [1:0]  rsp_status;
    logic [15:0] paddr;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;

    logic        d0_req_ready, d0_rsp_valid, d0_psel, d0_penable, d0_pwrite;
    logic [31:0] d0_rsp_read_data, d0_pwdata;
    logic [1:0]  d0_rsp_status;
    logic [15:0] d0_paddr;
    logic [2:0]  d0_pprot;
    logic [3:0]  d0_pstrb;

    int n_assert = 0;
    int n_fail   = 0;
    int pen_cnt;

    always #5 clk = ~clk;

    rggen_apb_bridge_master #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_address(req_address), .req_write(req_write),
        .req_write_data(req_write_data), .req_strobe(req_strobe),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_read_data(rsp_read_data), .rsp_status(rsp_status),
        .psel(psel), .penable(penable), .paddr(paddr), .pprot(pprot),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    rggen_apb_bridge_master dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(d0_req_ready),
        .req_address(req_address), .req_write(req_write),
        .req_write_data(req_write_data), .req_strobe(req_strobe),
        .req_prot(req_prot),
        .rsp_valid(d0_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_read_data(d0_rsp_read_data), .rsp_status(d0_rsp_status),
        .psel(d0_psel), .penable(d0_penable), .paddr(d0_paddr),
        .pprot(d0_pprot), .pwrite(d0_pwrite), .pwdata(d0_pwdata),
        .pstrb(d0_pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 0; req_address = 0; req_write = 0;
        req_write_data = 0; req_strobe = 0; req_prot = 0;
        rsp_ready = 0; pready = 0; prdata = 0; pslverr = 0;
        tick(); tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_psel", psel, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1);

        // read, pready immediately
        req_valid = 1; req_address = 16'h0010; req_write = 0;
        req_write_data = 32'hAAAA5555; req_strobe = 4'hF; req_prot = 3'b010;
        tick();
        req_valid = 0;
        chk("rd_c1_psel", psel, 1);
        chk("rd_c1_penable", penable, 0);
        chk("rd_c1_paddr", paddr, 16'h0010);
        chk("rd_c1_pstrb", pstrb, 0);
        chk("rd_c1_pwdata", pwdata, 32'hAAAA5555);
        chk("rd_c1_pprot", pprot, 3'b010);
        chk("rd_c1_pwrite", pwrite, 0);
        pready = 1; prdata = 32'hDEADBEEF;
        tick();
        chk("rd_c2_psel", psel, 1);
        chk("rd_c2_penable", penable, 1);
        chk("rd_c2_req_ready", req_ready, 0);
        tick();
        pready = 0; prdata = 0;
        chk("rd_c3_rsp_valid", rsp_valid, 1);
        chk("rd_c3_data", rsp_read_data, 32'hDEADBEEF);
        chk("rd_c3_status", rsp_status, 0);
        chk("rd_c3_psel", psel, 0);
        chk("rd_c3_penable", penable, 0);
        chk("rd_c3_d0_data", d0_rsp_read_data, 32'hDEADBEEF);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("rd_c4_rsp_valid", rsp_valid, 0);
        chk("rd_c4_req_ready", req_ready, 1);

        // write with three wait states; new req_valid while busy is ignored
        req_valid = 1; req_address = 16'h0124; req_write = 1;
        req_write_data = 32'h12345678; req_strobe = 4'b0011; req_prot = 3'b001;
        tick();
        req_address = 16'h7777; req_write_data = 32'h0; req_strobe = 4'hF;
        for (int c = 1; c <= 5; c++) begin
            chk("wr_psel", psel, 1);
            chk("wr_penable", penable, (c > 1) ? 1 : 0);
            chk("wr_paddr", paddr, 16'h0124);
            chk("wr_pwdata", pwdata, 32'h12345678);
            chk("wr_pstrb", pstrb, 4'b0011);
            if (c == 5) pready = 1;
            tick();
        end
        req_valid = 0; pready = 0;
        chk("wr_c6_rsp_valid", rsp_valid, 1);
        chk("wr_c6_status", rsp_status, 0);
        chk("wr_c6_data", rsp_read_data, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("wr_c7_req_ready", req_ready, 1);

        // read with slave error, response back-pressured
        req_valid = 1; req_address = 16'h0200; req_write = 0;
        tick();
        req_valid = 0;
        tick();
        pready = 1; pslverr = 1; prdata = 32'hCAFEF00D;
        tick();
        pready = 0; pslverr = 0; prdata = 0;
        for (int c = 3; c <= 6; c++) begin
            chk("err_rsp_valid", rsp_valid, 1);
            chk("err_status", rsp_status, 1);
            chk("err_data", rsp_read_data, 32'hCAFEF00D);
            tick();
        end
        rsp_ready = 1;
        chk("err_c7_rsp_valid", rsp_valid, 1);
        tick();
        rsp_ready = 0;
        chk("err_c8_req_ready", req_ready, 1);
        chk("err_c8_rsp_valid", rsp_valid, 0);

        // timeout: pready stuck low
        req_valid = 1; req_address = 16'h0300; req_write = 0;
        prdata = 32'h11111111;
        tick();
        req_valid = 0;
        pen_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            pen_cnt += int'(penable);
            tick();
        end
        chk("to_c6_psel", psel, 0);
        chk("to_c6_penable", penable, 0);
        chk("to_c6_rsp_valid", rsp_valid, 1);
        chk("to_c6_status", rsp_status, 2);
        chk("to_c6_data", rsp_read_data, 0);
        chk("to_pen_cycles", pen_cnt, 4);
        rsp_ready = 1;
        tick();
        chk("to_c7_req_ready", req_ready, 1);
        for (int c = 7; c < 12; c++) tick();
        chk("d0_no_timeout_penable", d0_penable, 1);
        chk("d0_no_timeout_rsp", d0_rsp_valid, 0);
        pready = 1;
        tick();
        pready = 0;
        chk("d0_late_rsp_valid", d0_rsp_valid, 1);
        chk("d0_late_status", d0_rsp_status, 0);
        chk("d0_late_data", d0_rsp_read_data, 32'h11111111);
        chk("to_ignored_rsp", rsp_valid, 0);
        tick();
        rsp_ready = 0;
        chk("d0_idle", d0_req_ready, 1);

        // pready in the 4th ACCESS cycle completes normally
        req_valid = 1; req_address = 16'h0304; prdata = 32'h0BADCAFE;
        tick();
        req_valid = 0;
        tick(); tick(); tick(); tick();
        pready = 1;
        tick();
        pready = 0;
        chk("edge_rsp_valid", rsp_valid, 1);
        chk("edge_status", rsp_status, 0);
        chk("edge_data", rsp_read_data, 32'h0BADCAFE);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("edge_idle", req_ready, 1);

        // reset mid-ACCESS
        req_valid = 1; req_address = 16'h0400;
        tick();
        req_valid = 0;
        tick();
        chk("rstm_in_access", penable, 1);
        rst = 1;
        tick();
        chk("rstm_psel", psel, 0);
        chk("rstm_penable", penable, 0);
        chk("rstm_rsp_valid", rsp_valid, 0);
        rst = 0;
        #1;
        chk("rstm_req_ready", req_ready, 1);
        tick();
        chk("rstm_no_rsp", rsp_valid, 0);
        chk("rstm_still_idle", psel, 0);

        // back-to-back with rsp_ready tied high
        rsp_ready = 1; pready = 1; req_valid = 1; req_write = 1;
        for (int c = 0; c < 12; c++) begin
            req_address = 16'(c);
            chk("b2b_req_ready", req_ready, (c % 4 == 0) ? 1 : 0);
            chk("b2b_rsp_valid", rsp_valid, (c % 4 == 3) ? 1 : 0);
            chk("b2b_psel", psel, (c % 4 == 1 || c % 4 == 2) ? 1 : 0);
            if (c == 11) req_valid = 0;
            tick();
        end
        chk("b2b_end_idle", req_ready, 1);
        rsp_ready = 0; pready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rggen_apb_bridge_master.md
RGGEN_APB_BRIDGE_MASTER -- requirements
Module: rggen_apb_bridge_master

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 16, SHALL set the paddr and req_address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width; strobe width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 0, SHALL set the maximum ACCESS cycles allowed; 0 disables the timeout.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
 clk  in  1  clock; all logic on rising edge
 rst  in  1  synchronous active-high reset
 req_valid  in  1  request valid
 req_ready  out  1  request accepted when req_valid && req_ready
 req_address  in  ADDRESS_WIDTH  byte address
 req_write  in  1  1 = write, 0 = read
 req_write_data  in  DATA_WIDTH  write data
 req_strobe  in  DATA_WIDTH/8  byte enables
 req_prot  in  3  protection attribute
 rsp_valid  out  1  response valid
 rsp_ready  in  1  response accepted when rsp_valid && rsp_ready
 rsp_read_data  out  DATA_WIDTH  captured prdata; 0 for writes and timeouts
 rsp_status  out  2  0 = OKAY, 1 = SLVERR, 2 = TIMEOUT
 psel, penable, paddr, pprot, pwrite, pwdata, pstrb  out  APB master signals
 pready, prdata, pslverr  in  APB completer signals

Function
REQ-005 The FSM SHALL have states IDLE, SETUP, ACCESS and RESPONSE.
REQ-006 req_ready SHALL be 1 only in IDLE, so at most one transaction is outstanding.
REQ-007 On accept in IDLE, the block SHALL register address, write, data, strobe and prot, and go to SETUP on the next cycle.
REQ-008 SETUP SHALL last exactly one cycle with psel=1 and penable=0, then go to ACCESS.
REQ-009 ACCESS SHALL drive psel=1 and penable=1 until pready=1 or timeout.
REQ-010 paddr, pprot, pwrite, pwdata and pstrb SHALL stay constant from SETUP through the last ACCESS cycle.
REQ-011 On reads, pstrb SHALL be 0; pwdata SHALL hold its registered value.
REQ-012 On an ACCESS cycle with pready=1, the block SHALL:
 - capture prdata (reads only) and pslverr (status 1 if set, else 0);
 - drop psel and penable on the next cycle;
 - go to RESPONSE.
REQ-013 With TIMEOUT_CYCLES=N>0, if pready is still 0 in the Nth ACCESS cycle, the block SHALL:
 - terminate the transfer (psel and penable drop the next cycle);
 - set status 2 and rsp_read_data 0;
 - go to RESPONSE.
REQ-014 pready=1 in the Nth ACCESS cycle SHALL complete the transfer normally, not as a timeout.
REQ-015 The ACCESS cycle counter SHALL clear on entry to SETUP and SHALL saturate rather than wrap.
REQ-016 In RESPONSE, rsp_valid=1 and rsp_read_data/rsp_status SHALL be held stable until rsp_ready=1; the next state is then IDLE.
REQ-017 If rsp_ready=1 in the first RESPONSE cycle, the next cycle SHALL be IDLE with req_ready=1 (no bubble beyond IDLE).
REQ-018 Latency SHALL be: accept at cycle 0, SETUP cycle 1, first ACCESS cycle 2; pready=1 at cycle k gives rsp_valid at cycle k+1.
REQ-019 pready, prdata and pslverr SHALL be ignored outside ACCESS.
REQ-020 req_valid in any state other than IDLE SHALL have no effect, and the request SHALL stay pending.

Reset
REQ-021 While rst=1, the block SHALL enter IDLE, abort any transfer, and drive all outputs to 0.
REQ-022 Reset asserted in ACCESS SHALL drop psel and penable on the next cycle, with no response generated.
REQ-023 After rst deasserts, req_ready SHALL be 1 on the first cycle.

Verification
REQ-024 Read, pready=1 immediately, address 0x0010, prdata 0xDEADBEEF -> psel rises at cycle 1, penable at cycle 2, rsp_valid at cycle 3 with data 0xDEADBEEF, status 0, pstrb=0.
REQ-025 Write of 0x12345678, strobe 0b0011, three wait states -> pwdata/pstrb/paddr stable for 5 cycles, rsp_valid at cycle 6, status 0, rsp_read_data 0.
REQ-026 Read with pslverr=1 on completion and rsp_ready held low 4 cycles -> status 1, response stable for 4 cycles, IDLE one cycle after rsp_ready rises.
REQ-027 TIMEOUT_CYCLES=4, pready stuck at 0 -> penable high for exactly 4 cycles, status 2, data 0; a second run with pready=1 in the 4th ACCESS cycle -> status 0.
REQ-028 rst pulsed mid-ACCESS -> psel=penable=0 the next cycle, no rsp_valid, req_ready=1 after release; back-to-back requests with rsp_ready tied high -> one transfer every 4 cycles.
